// File: rtl/timer_core_pkg.sv
// Shared definitions for the machine timer slice.
// Widths, the software-interrupt bit position, the default prescale and
// a helper that sizes the prescaler counter.
package timer_core_pkg;

  localparam int unsigned MTIME_W          = 64;
  localparam int unsigned MSIP_SIRQ_BIT    = 0;
  localparam int unsigned PRESCALE_DEFAULT = 1;

  typedef logic [MTIME_W-1:0] mtime_t;

  // Counter width for a prescaler of p cycles; never less than one bit.
  function automatic int unsigned prescale_width(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/timer_core_if.sv
// Register-block <-> timer_core bundle.
//   mtimecmp    : compare value            (reg block -> core)
//   msip        : software-interrupt reg   (reg block -> core)
//   mtime_we    : mtime half-load strobes  (reg block -> core)
//   mtime_wdata : mtime load data          (reg block -> core)
//   mtime       : current timer value      (core -> reg block)
// master = register block side, slave = timer_core side.
interface timer_core_if;
  import timer_core_pkg::*;

  mtime_t      mtimecmp;
  logic [31:0] msip;
  logic [1:0]  mtime_we;
  mtime_t      mtime_wdata;
  mtime_t      mtime;

  modport master (
    output mtimecmp, msip, mtime_we, mtime_wdata,
    input  mtime
  );

  modport slave (
    input  mtimecmp, msip, mtime_we, mtime_wdata,
    output mtime
  );

endinterface

// File: rtl/timer_prescaler.sv
// Divides clk down to a single-cycle tick every PRESCALE cycles.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (mtime load)
//   hold       : freeze the count and suppress tick (debug halt)
//   tick       : one-cycle pulse when the count reaches PRESCALE-1
module timer_prescaler
  import timer_core_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned     PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          at_max;

  assign at_max = (pcnt == PMAX);
  assign tick   = at_max & ~hold;

  // clr wins over hold so a load during halt still restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (!hold) begin
      if (at_max) pcnt <= '0;
      else        pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Machine timer functional core: free-running 64-bit mtime with prescaler,
// half-word loads, mtimecmp comparator and software-interrupt register.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : timer_core_if.slave (mtimecmp, msip, mtime_we,
//                mtime_wdata in; mtime out)
//   timer_irq  : level, registered (mtime >= mtimecmp)
//   soft_irq   : level, registered msip[0]
//   dbg_halt   : only with TIMER_DEBUG_HALT_EN; freezes counting
// Optional feature macro: TIMER_DEBUG_HALT_EN
module timer_core
  import timer_core_pkg::*;
#(
  parameter int unsigned PRESCALE  = PRESCALE_DEFAULT,
  parameter mtime_t      MTIME_RST = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  timer_core_if.slave   bus,
`ifdef TIMER_DEBUG_HALT_EN
  input  logic          dbg_halt,
`endif
  output logic          timer_irq,
  output logic          soft_irq
);

  mtime_t mtime_q;
  mtime_t mtime_inc;
  mtime_t mtime_nxt;
  logic   tick;
  logic   load;
  logic   hold;
  logic   unused_msip;

`ifdef TIMER_DEBUG_HALT_EN
  assign hold = dbg_halt;
`else
  assign hold = 1'b0;
`endif

  assign load        = |bus.mtime_we;
  assign unused_msip = ^bus.msip[31:1];

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .hold  (hold),
    .tick  (tick)
  );

  // Full-width increment first, then per-half load override, so a
  // non-loaded high half still sees the carry out of the old low word.
  always_comb begin
    mtime_inc = mtime_q + {{(MTIME_W-1){1'b0}}, tick};
    mtime_nxt = mtime_inc;
    if (bus.mtime_we[0]) mtime_nxt[31:0]  = bus.mtime_wdata[31:0];
    if (bus.mtime_we[1]) mtime_nxt[63:32] = bus.mtime_wdata[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q   <= MTIME_RST;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      mtime_q   <= mtime_nxt;
      timer_irq <= (mtime_q >= bus.mtimecmp);
      soft_irq  <= bus.msip[MSIP_SIRQ_BIT];
    end
  end

  assign bus.mtime = mtime_q;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: two instances (PRESCALE=1 and 4) share
// clock and reset; inputs change and outputs are checked 1 time unit
// after each rising edge.
module tb_timer_core;
  import timer_core_pkg::*;

  logic clk;
  logic rst_n;
  logic irq1, sirq1, irq4, sirq4;
`ifdef TIMER_DEBUG_HALT_EN
  logic halt1, halt4;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  timer_core_if bus1 ();
  timer_core_if bus4 ();

  timer_core #(
    .PRESCALE  (1),
    .MTIME_RST (64'h0)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
`ifdef TIMER_DEBUG_HALT_EN
    .dbg_halt  (halt1),
`endif
    .timer_irq (irq1),
    .soft_irq  (sirq1)
  );

  timer_core #(
    .PRESCALE  (4),
    .MTIME_RST (64'h0)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
`ifdef TIMER_DEBUG_HALT_EN
    .dbg_halt  (halt4),
`endif
    .timer_irq (irq4),
    .soft_irq  (sirq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus1.mtimecmp = 64'd10;  bus1.msip = '0; bus1.mtime_we = '0; bus1.mtime_wdata = '0;
    bus4.mtimecmp = '1;      bus4.msip = '0; bus4.mtime_we = '0; bus4.mtime_wdata = '0;
`ifdef TIMER_DEBUG_HALT_EN
    halt1 = 1'b0;
    halt4 = 1'b0;
`endif
    step(3);
    rst_n = 1'b1;

    // Reset state
    check("rst_mtime1", bus1.mtime, 64'd0);
    check("rst_irq1",   {63'd0, irq1}, 64'd0);
    check("rst_sirq1",  {63'd0, sirq1}, 64'd0);
    check("rst_mtime4", bus4.mtime, 64'd0);

    // PRESCALE=1 counts every clk; irq follows one clk after reaching cmp
    step(10);
    check("cnt10_mtime", bus1.mtime, 64'd10);
    check("cnt10_irq",   {63'd0, irq1}, 64'd0);
    step(1);
    check("cmp_irq_rise", {63'd0, irq1}, 64'd1);
    step(1);
    check("cmp_irq_hold", {63'd0, irq1}, 64'd1);
    // 12 edges since reset: PRESCALE=4 has ticked 3 times
    check("pre4_mtime12", bus4.mtime, 64'd3);

    // Mid-count low-word load on PRESCALE=4
    step(2);
    bus4.mtime_we = 2'b01; bus4.mtime_wdata = 64'h0000_0000_0000_0100;
    step(1);
    bus4.mtime_we = 2'b00;
    check("pre4_load", bus4.mtime, 64'h100);
    step(3);
    check("pre4_post3", bus4.mtime, 64'h100);
    step(1);
    check("pre4_post4", bus4.mtime, 64'h101);

    // Low-to-high carry and full wrap
    bus1.mtimecmp = 64'd5;
    bus1.mtime_we = 2'b11; bus1.mtime_wdata = 64'h0000_0000_FFFF_FFFF;
    step(1);
    bus1.mtime_we = 2'b00;
    check("carry_load", bus1.mtime, 64'h0000_0000_FFFF_FFFF);
    step(1);
    check("carry_inc", bus1.mtime, 64'h0000_0001_0000_0000);
    bus1.mtime_we = 2'b11; bus1.mtime_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1);
    bus1.mtime_we = 2'b00;
    check("wrap_load", bus1.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    check("wrap_zero", bus1.mtime, 64'd0);
    check("wrap_irq_still", {63'd0, irq1}, 64'd1);
    step(1);
    check("wrap_irq_drop", {63'd0, irq1}, 64'd0);

    // Raising mtimecmp above mtime clears irq one clk later
    bus1.mtimecmp = 64'h20;
    bus1.mtime_we = 2'b11; bus1.mtime_wdata = 64'h10;
    step(1);
    bus1.mtime_we = 2'b00;
    step(16);
    check("cmp20_mtime", bus1.mtime, 64'h20);
    check("cmp20_irq0",  {63'd0, irq1}, 64'd0);
    step(1);
    check("cmp20_irq1",  {63'd0, irq1}, 64'd1);
    bus1.mtimecmp = 64'h1000;
    step(1);
    check("cmp_raise_irq", {63'd0, irq1}, 64'd0);

    // High-half load on a tick cycle whose low word carries out
    bus1.mtime_we = 2'b11; bus1.mtime_wdata = 64'h0000_0000_FFFF_FFFF;
    step(1);
    bus1.mtime_we = 2'b10; bus1.mtime_wdata = 64'h1234_5678_0000_0000;
    step(1);
    bus1.mtime_we = 2'b00;
    check("hi_load_tick", bus1.mtime, 64'h1234_5678_0000_0000);

    // Software interrupt
    bus1.msip = 32'h0000_0001;
    check("sirq_before", {63'd0, sirq1}, 64'd0);
    step(1);
    check("sirq_set", {63'd0, sirq1}, 64'd1);
    bus1.msip = 32'hFFFF_FFFE;
    step(1);
    check("sirq_upper_ignored", {63'd0, sirq1}, 64'd0);

    // Asynchronous reset mid-count, then first tick PRESCALE clks later
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mtime1", bus1.mtime, 64'd0);
    check("async_rst_mtime4", bus4.mtime, 64'd0);
    check("async_rst_sirq",   {63'd0, sirq1}, 64'd0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("rerst_pre4_3", bus4.mtime, 64'd0);
    step(1);
    check("rerst_pre4_4", bus4.mtime, 64'd1);

`ifdef TIMER_DEBUG_HALT_EN
    // Halt with PRESCALE=4 part-way through a count
    step(2);
    halt4 = 1'b1;
    step(10);
    check("halt_hold", bus4.mtime, 64'd1);
    bus4.mtime_we = 2'b01; bus4.mtime_wdata = 64'h55;
    step(1);
    bus4.mtime_we = 2'b00;
    check("halt_load", bus4.mtime, 64'h55);
    step(9);
    check("halt_hold2", bus4.mtime, 64'h55);
    halt4 = 1'b0;
    step(3);
    check("halt_rel3", bus4.mtime, 64'h55);
    step(1);
    check("halt_rel4", bus4.mtime, 64'h56);
    // Release without a load resumes from the held count
    step(2);
    halt4 = 1'b1;
    step(5);
    halt4 = 1'b0;
    step(1);
    check("halt_resume1", bus4.mtime, 64'h56);
    step(1);
    check("halt_resume2", bus4.mtime, 64'h57);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
